lcd_cmd_regbank: RTL and testbench

Parametrised successor to the board top-level that feeds the LCD debug bus. It replaces constant debug values with a live register bank edited from the switches. A debounced strobe on the top switch executes one 2-bit command per press: select, load, add or step. Every LCD field, and the LEDs, show real registered state, so the display path can be exercised end-to-end on the board and in the simulator.

---
 rtl/lcd_cmd_regbank_if.sv | 39 +++
 rtl/lcd_cmd_regbank.sv | 166 ++++++++++++++++
 tb/tb_lcd_cmd_regbank.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_regbank_if.sv
// Bus bundle between the switch/LED/LCD debug harness and lcd_cmd_regbank.
// Carries the switch bank in, and the LED value plus every LCD debug field out.
//   slave  : the register bank (consumes SWI, drives everything else)
//   master : the board/testbench side (drives SWI, observes the rest)
interface lcd_cmd_regbank_if #(
    parameter int NBITS       = 8,
    parameter int NREGS       = 32,
    parameter int NINSTR_BITS = 32
);
    logic [NBITS-1:0]       SWI;
    logic [NBITS-1:0]       LED;
    logic [NINSTR_BITS-1:0] lcd_instruction;
    logic [NBITS-1:0]       lcd_registrador [0:NREGS-1];
    logic [NBITS-1:0]       lcd_pc;
    logic [NBITS-1:0]       lcd_SrcA;
    logic [NBITS-1:0]       lcd_SrcB;
    logic [NBITS-1:0]       lcd_ALUResult;
    logic [NBITS-1:0]       lcd_Result;
    logic [NBITS-1:0]       lcd_WriteData;
    logic [NBITS-1:0]       lcd_ReadData;
    logic                   lcd_MemWrite;
    logic                   lcd_Branch;
    logic                   lcd_MemtoReg;
    logic                   lcd_RegWrite;

    modport slave (
        input  SWI,
        output LED, lcd_instruction, lcd_registrador, lcd_pc, lcd_SrcA, lcd_SrcB,
               lcd_ALUResult, lcd_Result, lcd_WriteData, lcd_ReadData,
               lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite
    );

    modport master (
        output SWI,
        input  LED, lcd_instruction, lcd_registrador, lcd_pc, lcd_SrcA, lcd_SrcB,
               lcd_ALUResult, lcd_Result, lcd_WriteData, lcd_ReadData,
               lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite
    );
endinterface

// File: rtl/lcd_cmd_regbank.sv
// Switch-driven register bank feeding the LCD debug bus.
// A debounced press of SWI[NBITS-1] executes one 2-bit command
// (SELECT / LOAD / ADD / STEP) on an NREGS-entry register bank; every LCD
// field shows live registered state.
// Ports:
//   clk_2   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : lcd_cmd_regbank_if.slave (SWI in; LED and lcd_* out)
module lcd_cmd_regbank #(
    parameter int NBITS       = 8,
    parameter int NREGS       = 32,
    parameter int NINSTR_BITS = 32,
    parameter int DEBOUNCE    = 4,
    parameter bit R0_ZERO     = 1'b1
) (
    input  logic              clk_2,
    input  logic              reset_n,
    lcd_cmd_regbank_if.slave  bus
);
    localparam int OPW  = NBITS - 3;
    localparam int CW   = NINSTR_BITS - NBITS;
    localparam int SELW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CNTW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [NBITS:0]    NREGS_W = (NBITS+1)'(NREGS);
    localparam logic [CNTW-1:0]   CNT_MAX = CNTW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        OP_SELECT = 2'b00,
        OP_LOAD   = 2'b01,
        OP_ADD    = 2'b10,
        OP_STEP   = 2'b11
    } opcode_t;

    // input path
    logic [NBITS-1:0] s_meta, s;
    logic             stb_stable;
    logic [CNTW-1:0]  cnt;
    logic             debouncing;
    logic [NBITS-1:0] cmd_reg;
    logic             exec_pend;

    // architectural state
    logic [NBITS-1:0] regs [0:NREGS-1];
    logic [SELW-1:0]  sel;
    logic [NBITS-1:0] pc;
    logic [CW-1:0]    cmd_count;

    // last-command debug registers
    logic [NBITS-1:0] src_a, src_b, alu_result;
    logic             mem_to_reg, branch, reg_write;

    // execute datapath
    opcode_t          opc;
    logic [NBITS-1:0] op_ext, cur, res;
    logic [SELW-1:0]  sel_nxt;
    logic [NBITS-1:0] pc_nxt;
    logic             wr_en;

    assign opc    = opcode_t'(cmd_reg[NBITS-2:NBITS-3]);
    assign op_ext = NBITS'(cmd_reg[OPW-1:0]);
    assign cur    = regs[sel];

    always_comb begin
        sel_nxt = sel;
        pc_nxt  = pc;
        res     = op_ext;
        wr_en   = 1'b0;
        unique case (opc)
            OP_SELECT: begin
                // out-of-range index is silently ignored
                if ({1'b0, op_ext} < NREGS_W) sel_nxt = cmd_reg[SELW-1:0];
                res = NBITS'(sel_nxt);
            end
            OP_LOAD: begin
                res   = op_ext;
                wr_en = 1'b1;
            end
            OP_ADD: begin
                res   = cur + op_ext;
                wr_en = 1'b1;
            end
            OP_STEP: begin
                pc_nxt = pc + NBITS'(4);
                res    = pc_nxt;
            end
            default: ;
        endcase
        // hard-wired zero register: result still reported, write dropped
        if (R0_ZERO && (sel == '0)) wr_en = 1'b0;
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            s_meta     <= '0;
            s          <= '0;
            stb_stable <= 1'b0;
            cnt        <= '0;
            debouncing <= 1'b0;
            cmd_reg    <= '0;
            exec_pend  <= 1'b0;
            sel        <= '0;
            pc         <= '0;
            cmd_count  <= '0;
            src_a      <= '0;
            src_b      <= '0;
            alu_result <= '0;
            mem_to_reg <= 1'b0;
            branch     <= 1'b0;
            reg_write  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            s_meta    <= bus.SWI;
            s         <= s_meta;
            exec_pend <= 1'b0;

            // debounce: flip after DEBOUNCE consecutive disagreeing cycles
            if (s[NBITS-1] == stb_stable) begin
                cnt        <= '0;
                debouncing <= 1'b0;
            end else if (cnt == CNT_MAX) begin
                stb_stable <= s[NBITS-1];
                cnt        <= '0;
                debouncing <= 1'b0;
                if (s[NBITS-1]) begin
                    // snapshot opcode/operand together with the press
                    cmd_reg   <= s;
                    exec_pend <= 1'b1;
                end
            end else begin
                cnt        <= cnt + 1'b1;
                debouncing <= 1'b1;
            end

            if (exec_pend) begin
                sel        <= sel_nxt;
                pc         <= pc_nxt;
                cmd_count  <= cmd_count + 1'b1;
                src_a      <= cur;
                src_b      <= op_ext;
                alu_result <= res;
                mem_to_reg <= (opc == OP_LOAD);
                branch     <= (opc == OP_STEP);
                reg_write  <= wr_en;
                if (wr_en) regs[sel] <= res;
            end
        end
    end

    assign bus.LED             = cur;
    assign bus.lcd_ReadData    = cur;
    assign bus.lcd_instruction = {cmd_count, cmd_reg};
    assign bus.lcd_pc          = pc;
    assign bus.lcd_SrcA        = src_a;
    assign bus.lcd_SrcB        = src_b;
    assign bus.lcd_WriteData   = src_b;
    assign bus.lcd_ALUResult   = alu_result;
    assign bus.lcd_Result      = alu_result;
    assign bus.lcd_MemWrite    = debouncing;
    assign bus.lcd_Branch      = branch;
    assign bus.lcd_MemtoReg    = mem_to_reg;
    assign bus.lcd_RegWrite    = reg_write;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg_out
        assign bus.lcd_registrador[g] = regs[g];
    end
endmodule

// File: tb/tb_lcd_cmd_regbank.sv
module tb_lcd_cmd_regbank;
    localparam int NBITS = 8;
    localparam int NREGS = 32;
    localparam int NI    = 32;
    localparam int LAT   = 7;   // DEBOUNCE(4) + 3 edges

    logic clk_2 = 1'b0;
    logic reset_n;
    always #5 clk_2 = ~clk_2;

    lcd_cmd_regbank_if #(.NBITS(NBITS), .NREGS(NREGS), .NINSTR_BITS(NI)) bus ();

    lcd_cmd_regbank #(.NBITS(NBITS), .NREGS(NREGS), .NINSTR_BITS(NI),
                      .DEBOUNCE(4), .R0_ZERO(1'b1)) dut (
        .clk_2  (clk_2),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0]  swi;
        int          ridx;
        logic [7:0]  rval;
        logic [7:0]  led;
        logic [7:0]  alu;
        logic [7:0]  srca;
        logic        mtr, rw, br;
        logic [7:0]  pc;
        logic [23:0] cnt;
        int          exp_edge;
    } vec_t;

    vec_t  tbl[$];
    vec_t  sbq[$];
    int    n_chk = 0, n_pass = 0;
    int    edge_cnt = 0;
    logic [23:0] last_cnt = '0;
    logic  mw_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [7:0] swi, input int ridx, input logic [7:0] rval,
                       input logic [7:0] led, input logic [7:0] alu, input logic [7:0] srca,
                       input logic mtr, input logic rw, input logic br, input logic [7:0] pc);
        vec_t v;
        v.swi = swi; v.ridx = ridx; v.rval = rval; v.led = led; v.alu = alu;
        v.srca = srca; v.mtr = mtr; v.rw = rw; v.br = br; v.pc = pc;
        v.cnt = 24'(tbl.size() + 1); v.exp_edge = 0;
        tbl.push_back(v);
    endtask

    // Called every negedge: pops the scoreboard whenever a command retires.
    task automatic monitor();
        logic [23:0] cur;
        vec_t e;
        cur = bus.lcd_instruction[31:8];
        if (bus.lcd_MemWrite) mw_seen = 1'b1;
        if (!reset_n) last_cnt = '0;
        else if (cur != last_cnt) begin
            last_cnt = cur;
            chk("cmd_expected", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("latency",    edge_cnt, e.exp_edge);
                chk("cmd_count",  cur, e.cnt);
                chk("instr_swi",  bus.lcd_instruction[7:0], e.swi);
                chk("reg_val",    bus.lcd_registrador[e.ridx], e.rval);
                chk("led",        bus.LED, e.led);
                chk("readdata",   bus.lcd_ReadData, e.led);
                chk("aluresult",  bus.lcd_ALUResult, e.alu);
                chk("result",     bus.lcd_Result, e.alu);
                chk("srca",       bus.lcd_SrcA, e.srca);
                chk("srcb",       bus.lcd_SrcB, {3'b0, e.swi[4:0]});
                chk("writedata",  bus.lcd_WriteData, {3'b0, e.swi[4:0]});
                chk("flags",      {bus.lcd_MemtoReg, bus.lcd_RegWrite, bus.lcd_Branch},
                                  {e.mtr, e.rw, e.br});
                chk("pc",         bus.lcd_pc, e.pc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        edge_cnt++;
        @(negedge clk_2);
        monitor();
    endtask

    task automatic press(input vec_t v);
        bus.SWI = v.swi | 8'h80;
        v.exp_edge = edge_cnt + LAT;
        sbq.push_back(v);
        repeat (10) tick();
        bus.SWI = v.swi & 8'h7F;
        repeat (8) tick();
        chk("sb_drained", sbq.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < NREGS; i++) acc |= bus.lcd_registrador[i];
        chk({tag, "_regs"}, acc, 0);
        chk({tag, "_instr"}, bus.lcd_instruction, 0);
        chk({tag, "_led"}, bus.LED, 0);
        chk({tag, "_pc"}, bus.lcd_pc, 0);
        chk({tag, "_data"}, {bus.lcd_SrcA, bus.lcd_SrcB, bus.lcd_ALUResult, bus.lcd_Result}, 0);
        chk({tag, "_flags"}, {bus.lcd_MemWrite, bus.lcd_Branch, bus.lcd_MemtoReg,
                              bus.lcd_RegWrite, bus.lcd_WriteData, bus.lcd_ReadData}, 0);
    endtask

    initial begin
        vec_t v;
        reset_n = 1'b0;
        bus.SWI = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_cleared("reset");

        // SELECT 3, LOAD 5, ADD chain with wrap, r0 protection, STEP
        add(8'h83, 3, 8'd0, 8'd0, 8'd3, 8'd0, 0, 0, 0, 8'd0);
        add(8'hA5, 3, 8'd5, 8'd5, 8'd5, 8'd0, 1, 1, 0, 8'd0);
        for (int k = 1; k <= 8; k++)
            add(8'hDF, 3, 8'(5 + 31*k), 8'(5 + 31*k), 8'(5 + 31*k), 8'(5 + 31*(k-1)),
                0, 1, 0, 8'd0);
        add(8'hC1, 3, 8'hFE, 8'hFE, 8'hFE, 8'hFD, 0, 1, 0, 8'd0);
        add(8'hC3, 3, 8'h01, 8'h01, 8'h01, 8'hFE, 0, 1, 0, 8'd0);
        add(8'h9F, 31, 8'd0, 8'd0, 8'd31, 8'h01, 0, 0, 0, 8'd0);
        add(8'h80, 3, 8'h01, 8'd0, 8'd0, 8'd0, 0, 0, 0, 8'd0);
        add(8'hA7, 0, 8'd0, 8'd0, 8'd7, 8'd0, 1, 0, 0, 8'd0);
        add(8'hC2, 0, 8'd0, 8'd0, 8'd2, 8'd0, 0, 0, 0, 8'd0);
        add(8'hE0, 3, 8'h01, 8'd0, 8'd4, 8'd0, 0, 0, 1, 8'd4);
        for (int i = 0; i < tbl.size(); i++) press(tbl[i]);
        chk("seq_r3_final", bus.lcd_registrador[3], 8'h01);
        chk("seq_r0_final", bus.lcd_registrador[0], 8'h00);

        // 2-cycle strobe glitch: MemWrite pulses, nothing executes
        mw_seen = 1'b0;
        bus.SWI = 8'hE0;
        repeat (2) tick();
        bus.SWI = 8'h60;
        repeat (12) tick();
        chk("glitch_memwrite", mw_seen, 1);
        chk("glitch_no_cmd", bus.lcd_instruction[31:8], 17);
        chk("glitch_pc", bus.lcd_pc, 8'd4);
        chk("glitch_sb", sbq.size(), 0);

        // reset mid-count, strobe held high through release
        bus.SWI = 8'hE0;
        repeat (4) tick();
        chk("midcount_memwrite", bus.lcd_MemWrite, 1);
        reset_n = 1'b0;
        #1;
        check_cleared("midreset");
        repeat (3) tick();
        reset_n = 1'b1;
        v.swi = 8'hE0; v.ridx = 0; v.rval = 0; v.led = 0; v.alu = 8'd4; v.srca = 0;
        v.mtr = 0; v.rw = 0; v.br = 1; v.pc = 8'd4; v.cnt = 24'd1;
        v.exp_edge = edge_cnt + LAT;
        sbq.push_back(v);
        repeat (12) tick();
        bus.SWI = 8'h60;
        repeat (10) tick();
        chk("held_sb", sbq.size(), 0);
        chk("held_once", bus.lcd_instruction[31:8], 1);

        // STEP x65 from reset
        reset_n = 1'b0;
        bus.SWI = 8'h60;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        tbl.delete();
        for (int k = 1; k <= 65; k++)
            add(8'hE0, 0, 8'd0, 8'd0, 8'(4*k), 8'd0, 0, 0, 1, 8'(4*k));
        for (int i = 0; i < tbl.size(); i++) press(tbl[i]);
        chk("step65_pc", bus.lcd_pc, 8'h04);
        chk("step65_branch", bus.lcd_Branch, 1);
        begin
            logic [7:0] acc;
            acc = '0;
            for (int i = 0; i < NREGS; i++) acc |= bus.lcd_registrador[i];
            chk("step65_regs", acc, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
